// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/TRAP control, redirect with target
// alignment checking, and a fetch handshake that holds the request under backpressure.
module pc_sequencer #(
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]    RESET_VECTOR = {DATA_WIDTH{1'b0}},
  parameter logic [DATA_WIDTH-1:0]    TRAP_VECTOR  = DATA_WIDTH'(32'h0000_0100)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [1:0]            redirect_sel,
  input  logic [DATA_WIDTH-1:0] PCTarget,
  input  logic [DATA_WIDTH-1:0] JALRTarget,
  input  logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] PCounter,
  output logic [DATA_WIDTH-1:0] PCPlus4,
  output logic                  misalign_fault,
  output logic [DATA_WIDTH-1:0] fault_addr
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_TRAP = 2'b10
  } state_t;

  state_t                r_state;
  logic                  r_fetch_valid;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_fault;
  logic [DATA_WIDTH-1:0] r_fault_addr;

  logic [DATA_WIDTH-1:0] w_eff_target;
  logic                  w_misaligned;
  logic                  w_take_redirect;

  // Effective redirect target and its alignment check; trap targets are trusted.
  always_comb begin
    w_eff_target = PCTarget;
    case (redirect_sel)
      2'b00:   w_eff_target = PCTarget;
      2'b01:   w_eff_target = PCTarget;
      2'b10:   w_eff_target = JALRTarget & {{(DATA_WIDTH-1){1'b1}}, 1'b0};
      2'b11:   w_eff_target = TRAP_VECTOR;
      default: w_eff_target = PCTarget;
    endcase
    if (redirect_sel != 2'b11) begin
      w_misaligned = (w_eff_target[1:0] != 2'b00);
    end else begin
      w_misaligned = 1'b0;
    end
  end

  assign w_take_redirect = redirect_valid && (r_state != ST_TRAP);
  assign PCPlus4         = r_pc + {{(DATA_WIDTH-3){1'b0}}, 3'b100};

  // Sequencer state, PC and fault reporting; redirects outrank stall and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_fetch_valid <= 1'b0;
      r_pc          <= RESET_VECTOR;
      r_fault       <= 1'b0;
      r_fault_addr  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_fault <= 1'b0;
      if (w_take_redirect && w_misaligned) begin
        r_state       <= ST_TRAP;
        r_fetch_valid <= 1'b0;
        r_pc          <= TRAP_VECTOR;
        r_fault       <= 1'b1;
        r_fault_addr  <= w_eff_target;
      end else if (w_take_redirect) begin
        r_state       <= ST_RUN;
        r_fetch_valid <= 1'b1;
        r_pc          <= w_eff_target;
      end else begin
        case (r_state)
          ST_BOOT: begin
            r_state       <= ST_RUN;
            r_fetch_valid <= 1'b1;
          end
          ST_TRAP: begin
            r_state       <= ST_RUN;
            r_fetch_valid <= 1'b1;
          end
          ST_RUN: begin
            r_fetch_valid <= 1'b1;
            // The request stays up while fetch_ready is low; only a taken handshake advances.
            if (r_fetch_valid && fetch_ready && !stall) begin
              r_pc <= PCPlus4;
            end else begin
              r_pc <= r_pc;
            end
          end
          default: begin
            r_state       <= ST_BOOT;
            r_fetch_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fetch_valid    = r_fetch_valid;
  assign PCounter       = r_pc;
  assign misalign_fault = r_fault;
  assign fault_addr     = r_fault_addr;

endmodule
